sr_latch_driver: RTL and testbench
==================================

// Module: sr_latch_driver
// PURPOSE
//  Drives the s/r/enable inputs of a gated SR latch (DUT-under-control) from a queue of 2-bit
//  commands, holds each command for HOLD_CYCLES clocks, samples q/qb at the end of the hold, and
//  checks them against an internal expected-state model. Sits between a command source (bench
//  sequencer or lab controller) and the latch; replaces hand-timed #delay stimulus with clocked drive.
// PARAMETERS
//  HOLD_CYCLES  5  clocks each command is applied to the latch; legal range >= 2
//  CNT_W        $clog2(HOLD_CYCLES+1)  hold-counter width (derived, not overridden)
// PORTS
//  clk        in   1  single clock; all logic rising-edge
//  rst        in   1  synchronous, active-high reset
//  cmd_valid  in   1  command offered
//  cmd        in   2  00 HOLD (s0 r0), 01 RESET (s0 r1), 10 SET (s1 r0), 11 FORBID (s1 r1)
//  cmd_ready  out  1  high only in IDLE; transfer when cmd_valid & cmd_ready
//  s_out      out  1  latch s input (registered)
//  r_out      out  1  latch r input (registered)
//  en_out     out  1  latch enable/gate (registered), high only in DRIVE
//  q_in       in   1  latch q, already in clk domain
//  qb_in      in   1  latch qb, already in clk domain
//  resp_valid out  1  one-cycle pulse per completed command
//  resp_q     out  1  sampled q_in; stable until next resp_valid
//  resp_qb    out  1  sampled qb_in; stable until next resp_valid
//  resp_err   out  1  sampled pair mismatched expectation; stable until next resp_valid
//  busy       out  1  high in DRIVE and RESP
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): state=IDLE, s_out=r_out=en_out=0, resp_*=0, busy=0, cnt=0,
//   exp_known=0, exp_q=0. cmd_ready=1 from first cycle after reset deasserts.
//  FSM: IDLE -(cmd_valid)-> DRIVE -(cnt==HOLD_CYCLES-1)-> RESP -(always)-> IDLE.
//  Accept at edge T: cmd latched; from T+1 s_out/r_out per cmd, en_out=1, cnt counts 0..HOLD_CYCLES-1.
//  Sample q_in/qb_in at edge ending last DRIVE cycle; RESP cycle: resp_valid=1, s/r/en_out=0.
//  Latency accept->resp_valid = HOLD_CYCLES+1 clocks; throughput 1 cmd per HOLD_CYCLES+2 clocks
//   (RESP + IDLE cycle; cmd_ready low in RESP, so back-to-back accept never occurs in RESP).
//  Expected model (updated at RESP):
//   SET: exp_q=1, exp_known=1; err = !(q==1 && qb==0).
//   RESET: exp_q=0, exp_known=1; err = !(q==0 && qb==1).
//   HOLD, exp_known=1: err = !(q==exp_q && qb==!exp_q); HOLD, exp_known=0: err = (q==qb).
//   FORBID: err = !(q==0 && qb==0) (NOR latch both outputs low); then exp_known=0.
//  cmd ignored when cmd_ready=0; cmd value outside DRIVE has no effect on outputs.
//  rst during DRIVE/RESP: command aborted, no resp_valid, latch inputs drop to 0 same edge.
//  HOLD_CYCLES<2: elaboration error ($error in initial/generate check).
// STRUCTURE
//  sr_drv_pkg: typedef enum logic[1:0] sr_cmd_t {CMD_HOLD, CMD_RESET, CMD_SET, CMD_FORBID};
//   typedef enum logic[1:0] sr_drv_state_t {ST_IDLE, ST_DRIVE, ST_RESP}.
//  Sub-module sr_expect_model: holds exp_q/exp_known, takes cmd + sampled pair, returns err
//   and next model state; top keeps FSM, counter, output registers.
// TESTING  (HOLD_CYCLES=5; bench latch model = gated NOR latch)
//  Reset then SET: cmd=10 at T -> s_out=1 T+1..T+5, resp_valid at T+6, resp_q=1 resp_qb=0 err=0.
//  SET, HOLD, RESET, HOLD -> resp_q 1,1,0,0; err all 0; cmd_ready low exactly T+1..T+6 each.
//  FORBID then HOLD -> FORBID resp q=0 qb=0 err=0; HOLD with unknown state err=0 iff q!=qb.
//  Fault inject: latch q stuck-at-0, cmd SET -> resp_err=1, resp_q=0.
//  rst asserted at cnt=2 of a SET -> next edge s_out=en_out=0, no resp_valid, cmd_ready=1 after.
//  cmd_valid held high continuously with 4 cmds -> exactly 4 resp_valid pulses, 7 clocks apart.

Source files
------------

// File: rtl/sr_drv_pkg.sv
// Shared types for the SR latch driver: command encoding and controller states.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD   = 2'b00,
        CMD_RESET  = 2'b01,
        CMD_SET    = 2'b10,
        CMD_FORBID = 2'b11
    } sr_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_RESP  = 2'b10
    } sr_drv_state_t;

    // Command bits map directly onto the latch inputs: {s, r}.
    function automatic logic [1:0] cmd_to_sr(input sr_cmd_t c);
        return logic'(c[1]) ? {1'b1, c[0]} : {1'b0, c[0]};
    endfunction

endpackage

// File: rtl/sr_latch_driver_model.sv
// Expected-state model of the driven latch: judges a sampled q/qb pair against the
// command that produced it and tracks whether the stored latch value is known.
module sr_expect_model
    import sr_drv_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    update,
    input  sr_cmd_t cmd,
    input  logic    q,
    input  logic    qb,
    output logic    err
);

    logic exp_q;
    logic exp_known;

    always_comb begin
        err = 1'b0;
        case (cmd)
            CMD_SET:    err = !(q && !qb);
            CMD_RESET:  err = !(!q && qb);
            CMD_HOLD:   err = exp_known ? !((q == exp_q) && (qb == !exp_q)) : (q == qb);
            CMD_FORBID: err = !(!q && !qb);
            default:    err = 1'b0;
        endcase
    end

    // After FORBID the latch resolves unpredictably, so only complementarity can be checked.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q     <= 1'b0;
            exp_known <= 1'b0;
        end else if (update) begin
            case (cmd)
                CMD_SET: begin
                    exp_q     <= 1'b1;
                    exp_known <= 1'b1;
                end
                CMD_RESET: begin
                    exp_q     <= 1'b0;
                    exp_known <= 1'b1;
                end
                CMD_FORBID: exp_known <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sr_latch_driver.sv
// Clocked driver for a gated SR latch: applies one command for HOLD_CYCLES clocks,
// samples q/qb at the end of the hold and reports the pair with a model-checked error flag.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 5,
    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic       s_out,
    output logic       r_out,
    output logic       en_out,
    input  logic       q_in,
    input  logic       qb_in,
    output logic       resp_valid,
    output logic       resp_q,
    output logic       resp_qb,
    output logic       resp_err,
    output logic       busy
);

    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("sr_latch_driver: HOLD_CYCLES must be >= 2");
    end

    sr_drv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    sr_cmd_t          cmd_q;
    logic             accept;
    logic             last_drive;
    logic             model_err;

    assign accept     = cmd_valid && cmd_ready;
    assign last_drive = (state_q == ST_DRIVE) && (cnt_q == CNT_W'(HOLD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_valid) state_d = ST_DRIVE;
            ST_DRIVE: if (last_drive) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q == ST_DRIVE) || (state_q == ST_RESP);
    end

    // Latch inputs and response fields are registered so the latch sees clean, glitch-free drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            cmd_q      <= CMD_HOLD;
            s_out      <= 1'b0;
            r_out      <= 1'b0;
            en_out     <= 1'b0;
            resp_valid <= 1'b0;
            resp_q     <= 1'b0;
            resp_qb    <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            if (accept) begin
                cmd_q            <= sr_cmd_t'(cmd);
                {s_out, r_out}   <= cmd_to_sr(sr_cmd_t'(cmd));
                en_out           <= 1'b1;
                cnt_q            <= '0;
            end else if (last_drive) begin
                s_out      <= 1'b0;
                r_out      <= 1'b0;
                en_out     <= 1'b0;
                resp_valid <= 1'b1;
                resp_q     <= q_in;
                resp_qb    <= qb_in;
                resp_err   <= model_err;
            end else if (state_q == ST_DRIVE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    sr_expect_model u_model (
        .clk    (clk),
        .rst    (rst),
        .update (last_drive),
        .cmd    (cmd_q),
        .q      (q_in),
        .qb     (qb_in),
        .err    (model_err)
    );

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: drives it against a behavioural gated NOR latch and checks
// timing and responses against a rule-level model of the expected latch state.
module tb_sr_latch_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmd_ready, s_out, r_out, en_out, q_in, qb_in;
    logic       resp_valid, resp_q, resp_qb, resp_err, busy;

    bit lq = 1'b0, lqb = 1'b1, stuck = 1'b0;
    bit smp_q, smp_qb;
    bit m_known = 1'b0, m_q = 1'b0;
    int n_cmp = 0, n_fail = 0;

    typedef struct {
        int       resp_cyc;
        int       pulses;
        bit [7:0] rdy, en, s, r;
        bit       rq, rqb, rerr, sq, sqb;
    } obs_t;

    sr_latch_driver #(.HOLD_CYCLES(5)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .s_out(s_out), .r_out(r_out), .en_out(en_out), .q_in(q_in), .qb_in(qb_in),
        .resp_valid(resp_valid), .resp_q(resp_q), .resp_qb(resp_qb), .resp_err(resp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign q_in  = stuck ? 1'b0 : lq;
    assign qb_in = lqb;

    // What the driver should have captured at each edge.
    always @(posedge clk) begin
        smp_q  <= q_in;
        smp_qb <= qb_in;
    end

    // Gated NOR latch; leaving the forbidden state resolves to a random valid value.
    always @(s_out or r_out or en_out) begin
        if (en_out && s_out && !r_out) begin lq = 1'b1; lqb = 1'b0; end
        else if (en_out && !s_out && r_out) begin lq = 1'b0; lqb = 1'b1; end
        else if (en_out && s_out && r_out) begin lq = 1'b0; lqb = 1'b0; end
        else if (lq == lqb) begin lq = 1'($urandom_range(0, 1)); lqb = !lq; end
    end

    task automatic model_resp(input logic [1:0] c, input bit q, input bit qb, output bit e);
        case (c)
            2'b10: begin e = !(q == 1'b1 && qb == 1'b0); m_q = 1'b1; m_known = 1'b1; end
            2'b01: begin e = !(q == 1'b0 && qb == 1'b1); m_q = 1'b0; m_known = 1'b1; end
            2'b00: e = m_known ? !(q == m_q && qb == !m_q) : (q == qb);
            default: begin e = (q || qb); m_known = 1'b0; end
        endcase
    endtask

    task automatic drive_cmd(input logic [1:0] c, output obs_t o);
        int w = 0;
        o = '{resp_cyc: -1, default: 0};
        @(negedge clk);
        while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        cmd = c;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin cmd_valid = 1'b0; cmd = 2'($urandom); end
            o.rdy[k-1] = cmd_ready; o.en[k-1] = en_out; o.s[k-1] = s_out; o.r[k-1] = r_out;
            if (resp_valid) begin
                o.pulses++;
                if (o.resp_cyc < 0) begin
                    o.resp_cyc = k; o.rq = resp_q; o.rqb = resp_qb; o.rerr = resp_err;
                    o.sq = smp_q; o.sqb = smp_qb;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({s_out, r_out, en_out, resp_valid, resp_q, resp_qb, resp_err, busy} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {s_out, r_out, en_out, resp_valid, resp_q, resp_qb, resp_err, busy});
        end
        rst = 1'b0;
        m_known = 1'b0; m_q = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got ready=%b busy=%b expected 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_set();
        obs_t o; bit e;
        drive_cmd(2'b10, o);
        model_resp(2'b10, o.sq, o.sqb, e);
        n_cmp++;
        if (o.resp_cyc != 6 || o.pulses != 1) begin
            n_fail++; $display("FAIL set_latency: got cyc=%0d pulses=%0d expected 6/1", o.resp_cyc, o.pulses);
        end
        n_cmp++;
        if (o.s !== 8'h1F || o.r !== 8'h00 || o.en !== 8'h1F) begin
            n_fail++; $display("FAIL set_drive: got s=%h r=%h en=%h expected 1f/00/1f", o.s, o.r, o.en);
        end
        n_cmp++;
        if (o.rdy !== 8'hC0) begin
            n_fail++; $display("FAIL set_ready: got %h expected c0", o.rdy);
        end
        n_cmp++;
        if ({o.rq, o.rqb, o.rerr} !== {2'b10, e}) begin
            n_fail++; $display("FAIL set_resp: got q/qb/err=%b%b%b expected 10%b", o.rq, o.rqb, o.rerr, e);
        end
    endtask

    task automatic test_sequence();
        logic [1:0] cl[4] = '{2'b10, 2'b00, 2'b01, 2'b00};
        bit         eq[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        obs_t o; bit e;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(cl[i], o);
            model_resp(cl[i], o.sq, o.sqb, e);
            n_cmp++;
            if (o.rq !== eq[i] || o.rqb !== !eq[i] || o.rerr !== e || e !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_resp[%0d]: got q=%b qb=%b err=%b expected q=%b qb=%b err=0",
                         i, o.rq, o.rqb, o.rerr, eq[i], !eq[i]);
            end
            n_cmp++;
            if (o.rdy !== 8'hC0 || o.resp_cyc != 6) begin
                n_fail++; $display("FAIL seq_ready[%0d]: got rdy=%h cyc=%0d expected c0/6", i, o.rdy, o.resp_cyc);
            end
            n_cmp++;
            if (resp_q !== eq[i] || resp_valid !== 1'b0) begin
                n_fail++; $display("FAIL seq_hold[%0d]: got q=%b valid=%b expected %b/0", i, resp_q, resp_valid, eq[i]);
            end
        end
    endtask

    task automatic test_forbid();
        obs_t o; bit e;
        drive_cmd(2'b11, o);
        model_resp(2'b11, o.sq, o.sqb, e);
        n_cmp++;
        if ({o.rq, o.rqb, o.rerr} !== 3'b000 || o.s !== 8'h1F || o.r !== 8'h1F) begin
            n_fail++;
            $display("FAIL forbid_resp: got q/qb/err=%b%b%b s=%h r=%h expected 000/1f/1f",
                     o.rq, o.rqb, o.rerr, o.s, o.r);
        end
        drive_cmd(2'b00, o);
        model_resp(2'b00, o.sq, o.sqb, e);
        n_cmp++;
        if (o.rerr !== e || o.resp_cyc != 6) begin
            n_fail++; $display("FAIL forbid_hold: got err=%b cyc=%0d expected %b/6", o.rerr, o.resp_cyc, e);
        end
    endtask

    task automatic test_fault();
        obs_t o; bit e;
        stuck = 1'b1;
        drive_cmd(2'b10, o);
        model_resp(2'b10, o.sq, o.sqb, e);
        stuck = 1'b0;
        n_cmp++;
        if (o.rq !== 1'b0 || o.rerr !== 1'b1 || e !== 1'b1) begin
            n_fail++; $display("FAIL fault_stuck: got q=%b err=%b expected 0/1", o.rq, o.rerr);
        end
    endtask

    task automatic test_abort();
        int w = 0, pulses = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
        cmd_valid = 1'b1; cmd = 2'b10;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (s_out !== 1'b1 || en_out !== 1'b1) begin
            n_fail++; $display("FAIL abort_pre: got s=%b en=%b expected 1/1", s_out, en_out);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({s_out, r_out, en_out, resp_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL abort_drop: got s/r/en/valid=%b expected 0000", {s_out, r_out, en_out, resp_valid});
        end
        rst = 1'b0;
        m_known = 1'b0; m_q = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_ready: got %b expected 1", cmd_ready);
        end
        for (int k = 0; k < 10; k++) begin
            if (resp_valid) pulses++;
            @(negedge clk);
        end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++; $display("FAIL abort_noresp: got %0d pulses expected 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] cl[4];
        logic [1:0] pend[$];
        logic [1:0] c;
        int idx = 0, pulses = 0, last_t = -1;
        bit fire, e;
        foreach (cl[i]) cl[i] = 2'($urandom);
        @(negedge clk);
        cmd_valid = 1'b1; cmd = cl[0];
        for (int cyc = 0; cyc < 80; cyc++) begin
            fire = cmd_valid && cmd_ready;
            @(negedge clk);
            if (fire) begin
                pend.push_back(cl[idx]); idx++;
                cmd_valid = (idx < 4);
                if (idx < 4) cmd = cl[idx];
            end
            if (resp_valid) begin
                pulses++;
                c = (pend.size() > 0) ? pend.pop_front() : 2'b00;
                model_resp(c, smp_q, smp_qb, e);
                n_cmp++;
                if (resp_err !== e || resp_q !== smp_q || resp_qb !== smp_qb) begin
                    n_fail++;
                    $display("FAIL b2b_resp[%0d]: got q/qb/err=%b%b%b expected %b%b%b",
                             pulses, resp_q, resp_qb, resp_err, smp_q, smp_qb, e);
                end
                if (last_t >= 0) begin
                    n_cmp++;
                    if (cyc - last_t != 7) begin
                        n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected 7", pulses, cyc - last_t);
                    end
                end
                last_t = cyc;
            end
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (pulses != 4) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 4", pulses);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_set();
        test_sequence();
        test_forbid();
        test_fault();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
